// File: rtl/mem_bist_engine.sv
// mem_bist_engine
//   Memory built-in-self-test sequencer. It writes a selectable data pattern
//   over an inclusive address window, reads the window back and compares
//   every word. It reports pass/fail, a saturating mismatch count and the
//   first failing address together with its expected and read data.
//   Requests go to ram_ctrl over a single-word request/ready handshake, and
//   at most one access is outstanding at a time.
//
// Ports
//   clk, sys_rst        : clock, asynchronous active-high reset
//   start, abort        : begin a test (sampled in IDLE) / stop at the next
//                         access boundary
//   mode, pattern       : 0 addr-as-data, 1 walking-ones, 2 LFSR,
//                         3 checkerboard of pattern
//   addr_lo, addr_hi    : inclusive test window
//   mem_req/we/addr/wdata, mem_rdy/rdata : ram_ctrl handshake
//   busy, done, pass, cfg_err            : status
//   err_cnt, first_err_addr/exp/act      : error report
module mem_bist_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 23,
  parameter int ERR_W  = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY = 16'hB400,
  parameter logic [DATA_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              cfg_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int WALK_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addrCur;
  logic [ADDR_W-1:0] addrLo;
  logic [ADDR_W-1:0] addrHi;
  logic [1:0]        modeLat;
  logic [DATA_W-1:0] patLat;
  logic [DATA_W-1:0] lfsr;
  logic [WALK_W-1:0] walkPos;   // index modulo DATA_W, kept as a counter to avoid a divider
  logic              oddIdx;    // bit 0 of the index within the window
  logic              abortSeen;

  logic [DATA_W-1:0] addrData;
  logic [DATA_W-1:0] oneHot;
  logic [DATA_W-1:0] expData;

  // Galois LFSR step: shift right, fold the tap mask in when a one falls out.
  function automatic logic [DATA_W-1:0] lfsrStep(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v[0]) begin
      r = (v >> 1) ^ LFSR_POLY;
    end else begin
      r = v >> 1;
    end
    return r;
  endfunction

  // Address-as-data uses the low address bits, zero-extended for narrow addresses.
  generate
    if (ADDR_W >= DATA_W) begin : gAddrWide
      assign addrData = addrCur[DATA_W-1:0];
    end else begin : gAddrNarrow
      assign addrData = {{(DATA_W-ADDR_W){1'b0}}, addrCur};
    end
  endgenerate

  assign oneHot = {{(DATA_W-1){1'b0}}, 1'b1} << walkPos;

  // Pattern word for the current address; the same value is written and later expected.
  always_comb begin
    expData = '0;
    case (modeLat)
      2'd0:    expData = addrData;
      2'd1:    expData = oneHot;
      2'd2:    expData = lfsr;
      2'd3:    expData = patLat ^ {DATA_W{oddIdx}};
      default: expData = '0;
    endcase
  end

  // Sequencer state, access handshake and result registers.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      addrCur        <= '0;
      addrLo         <= '0;
      addrHi         <= '0;
      modeLat        <= 2'd0;
      patLat         <= '0;
      lfsr           <= LFSR_SEED;
      walkPos        <= '0;
      oddIdx         <= 1'b0;
      abortSeen      <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      cfg_err        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_act  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (addr_hi < addr_lo) begin
              cfg_err <= 1'b1;
              pass    <= 1'b0;
              done    <= 1'b1;
            end else begin
              modeLat        <= mode;
              patLat         <= pattern;
              addrLo         <= addr_lo;
              addrHi         <= addr_hi;
              addrCur        <= addr_lo;
              walkPos        <= '0;
              oddIdx         <= 1'b0;
              lfsr           <= LFSR_SEED;
              abortSeen      <= 1'b0;
              err_cnt        <= '0;
              first_err_addr <= '0;
              first_err_exp  <= '0;
              first_err_act  <= '0;
              pass           <= 1'b0;
              cfg_err        <= 1'b0;
              busy           <= 1'b1;
              state          <= WRITE;
            end
          end
        end

        WRITE, READ: begin
          if (!mem_req) begin
            // Gap cycle between accesses: either issue the next one or honour an abort.
            if (abortSeen || abort) begin
              abortSeen <= 1'b1;
              state     <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= (state == WRITE);
              mem_addr  <= addrCur;
              mem_wdata <= (state == WRITE) ? expData : '0;
            end
          end else if (mem_rdy) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            lfsr    <= lfsrStep(lfsr);
            if ((state == READ) && (mem_rdata != expData)) begin
              if (err_cnt == '0) begin
                first_err_addr <= addrCur;
                first_err_exp  <= expData;
                first_err_act  <= mem_rdata;
              end
              if (!(&err_cnt)) begin
                err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
              end
            end
            // Compare against addrHi before incrementing so an all-ones limit never wraps.
            if (abortSeen || abort) begin
              abortSeen <= 1'b1;
              state     <= DONE;
            end else if (addrCur == addrHi) begin
              if (state == WRITE) begin
                state   <= READ;
                addrCur <= addrLo;
                walkPos <= '0;
                oddIdx  <= 1'b0;
                lfsr    <= LFSR_SEED;
              end else begin
                state <= DONE;
              end
            end else begin
              addrCur <= addrCur + {{(ADDR_W-1){1'b0}}, 1'b1};
              walkPos <= (walkPos == WALK_W'(DATA_W-1)) ? '0 : walkPos + {{(WALK_W-1){1'b0}}, 1'b1};
              oddIdx  <= ~oddIdx;
            end
          end else if (abort) begin
            abortSeen <= 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b1;
          pass  <= (err_cnt == '0) && !abortSeen;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
